ntt_sequencer: RTL

Control block that drives one `butterfly` instance through a whole 256-coefficient Dilithium polynomial operation. Supported operations are the forward NTT, the inverse NTT, pointwise multiply-accumulate, add and subtract.
- It generates coefficient-RAM and zeta-ROM read addresses, and it pulses the butterfly `validi`.
- It tracks every in-flight operation in an address delay line and produces the matching write-back strobes.
- Between NTT layers it stalls, so a layer never reads a coefficient that the previous layer has not yet written.

---
 rtl/ntt_sequencer_if.sv | 32 +++
 rtl/ntt_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_sequencer_if.sv
// Bundle of the sequencer's handshake, butterfly-control, RAM-read and write-back signals.
// The sequencer connects through the slave modport. The driver or bench connects through master.
interface ntt_sequencer_if;
    logic       start;
    logic [2:0] op;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] bf_mode;
    logic       bf_validi;
    logic       bf_valido;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [7:0] zeta_addr;
    logic       wr_en_a;
    logic       wr_en_b;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;

    modport master (
        output start, op, bf_valido,
        input  busy, done, err, bf_mode, bf_validi, rd_en, rd_addr_a, rd_addr_b,
               zeta_addr, wr_en_a, wr_en_b, wr_addr_a, wr_addr_b
    );

    modport slave (
        input  start, op, bf_valido,
        output busy, done, err, bf_mode, bf_validi, rd_en, rd_addr_a, rd_addr_b,
               zeta_addr, wr_en_a, wr_en_b, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_sequencer.sv
// Sequencer that drives one butterfly through a full 256-coefficient Dilithium operation:
// forward/inverse NTT (8 layers of 128 butterflies) or one pointwise pass (PWM/ADD/SUB).
// Every issued butterfly is tracked in an address delay line whose length matches the
// read latency plus the butterfly latency of the latched operation. The head of that line
// produces the write-back strobes.
module ntt_sequencer #(
    parameter int RD_LAT     = 1,
    parameter int LAT_NTT    = 8,
    parameter int LAT_INTT   = 9,
    parameter int LAT_PWM    = 8,
    parameter int LAT_ADDSUB = 4
) (
    input  logic            clk,
    input  logic            rst,
    ntt_sequencer_if.slave  bus
);

    localparam logic [2:0] OP_FWD = 3'd0;
    localparam logic [2:0] OP_INV = 3'd1;
    localparam logic [2:0] OP_PWM = 3'd2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int LAT_M0   = (LAT_NTT > LAT_INTT) ? LAT_NTT : LAT_INTT;
    localparam int LAT_M1   = (LAT_PWM > LAT_ADDSUB) ? LAT_PWM : LAT_ADDSUB;
    localparam int LAT_MAX  = (LAT_M0 > LAT_M1) ? LAT_M0 : LAT_M1;
    localparam int DL_DEPTH = RD_LAT + LAT_MAX;

    typedef struct packed {
        logic       vld;
        logic [7:0] a;
        logic [7:0] b;
    } dl_entry_t;

    logic [1:0] state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] layer_q, layer_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       rd_en_q, issue_d;
    logic [7:0] addr_a_q, addr_a_d;
    logic [7:0] addr_b_q, addr_b_d;
    logic [7:0] zeta_q, zeta_d;
    logic [RD_LAT-1:0] vld_pipe_q;
    dl_entry_t  dl_q [DL_DEPTH];
    dl_entry_t  push;
    dl_entry_t  pop;
    logic       pre_vld;
    logic       last_issue;
    int         dl_entry;

    // True for the two layered transforms, false for the single-pass pointwise operations.
    function automatic logic is_ntt(input logic [2:0] m);
        return (m == OP_FWD) || (m == OP_INV);
    endfunction

    // Butterfly latency for a given operation code. Unknown codes behave like ADD/SUB.
    function automatic int op_lat(input logic [2:0] m);
        case (m)
            OP_FWD:  return LAT_NTT;
            OP_INV:  return LAT_INTT;
            OP_PWM:  return LAT_PWM;
            default: return LAT_ADDSUB;
        endcase
    endfunction

    // Read addresses {j, j+len, k} for issue counter c of layer l.
    // len is a power of two and j never has the len bit set, so j+len is j | len.
    function automatic logic [23:0] issue_addr(input logic [2:0] m, input logic [2:0] l,
                                               input logic [7:0] c);
        logic [7:0] bi, len, g, j, k;
        logic [8:0] kk;
        bi = {1'b0, c[6:0]};
        if (m == OP_FWD) begin
            len = 8'd128 >> l;
            g   = bi >> (3'd7 - l);
            j   = (g << (4'd8 - {1'b0, l})) | (bi & (len - 8'd1));
            k   = (8'd1 << l) + g;
            return {j, j | len, k};
        end else if (m == OP_INV) begin
            len = 8'd1 << l;
            g   = bi >> l;
            j   = (g << ({1'b0, l} + 4'd1)) | (bi & (len - 8'd1));
            kk  = (9'd256 >> l) - 9'd1 - {1'b0, g};
            k   = kk[7:0];
            return {j, j | len, k};
        end
        return {c, c, c};
    endfunction

    assign last_issue = is_ntt(mode_q) ? (cnt_q[6:0] == 7'h7f) : (cnt_q == 8'hff);
    assign dl_entry   = LAT_MAX - op_lat(mode_q);
    assign push       = '{vld: rd_en_q, a: addr_a_q, b: addr_b_q};
    assign pop        = dl_q[DL_DEPTH-1];
    assign pre_vld    = dl_q[DL_DEPTH-2].vld;

    // Next-state logic: FSM sequencing, counters and the mismatch check for err.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        layer_d = layer_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        issue_d = 1'b0;
        err_d   = err_q | (bus.bf_valido ^ pop.vld);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ISSUE;
                    mode_d  = bus.op;
                    cnt_d   = 8'd0;
                    layer_d = 3'd0;
                    busy_d  = 1'b1;
                    issue_d = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    issue_d = 1'b1;
                end
            end
            S_DRAIN: begin
                // Head holds the last write of this layer/pass when nothing valid follows it.
                if (pop.vld && !pre_vld) begin
                    if (is_ntt(mode_q) && (layer_q != 3'd7)) begin
                        state_d = S_ISSUE;
                        layer_d = layer_q + 3'd1;
                        cnt_d   = 8'd0;
                        issue_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (issue_d) begin
            {addr_a_d, addr_b_d, zeta_d} = issue_addr(mode_d, layer_d, cnt_d);
        end else begin
            {addr_a_d, addr_b_d, zeta_d} = 24'd0;
        end
    end

    // Control state, counters and registered read-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 3'd0;
            cnt_q    <= 8'd0;
            layer_q  <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_a_q <= 8'd0;
            addr_b_q <= 8'd0;
            zeta_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            layer_q  <= layer_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rd_en_q  <= issue_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            zeta_q   <= zeta_d;
        end
    end

    // Issue strobe delayed by the read latency so bf_validi lines up with the read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= rd_en_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
        end
    end

    // Address delay line. Entries enter partway along the line, chosen by the latched
    // operation, so the head is always a plain register. Stages ahead of the entry point stay clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DL_DEPTH; k++) begin
                dl_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DL_DEPTH; k++) begin
                if (k == dl_entry) begin
                    dl_q[k] <= push;
                end else if (k > dl_entry) begin
                    dl_q[k] <= dl_q[(k > 0) ? k - 1 : 0];
                end else begin
                    dl_q[k] <= '0;
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.bf_mode   = mode_q;
    assign bus.bf_validi = vld_pipe_q[RD_LAT-1];
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = addr_a_q;
    assign bus.rd_addr_b = addr_b_q;
    assign bus.zeta_addr = zeta_q;
    assign bus.wr_en_a   = pop.vld & is_ntt(mode_q);
    assign bus.wr_en_b   = pop.vld;
    assign bus.wr_addr_a = pop.a;
    assign bus.wr_addr_b = pop.b;

endmodule
